// File: rtl/niosii_system_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : niosii_system_st_packetizer
// Purpose  : Avalon-ST source that frames a raw byte stream into 10-bit
//            {sop, eop, data[7:0]} beats, with one packet per PKT_LEN bytes.
//            An output register plus one skid register give one beat per
//            clock while in_ready stays a registered output.
// Options  : NIOSII_PACKETIZER_STATS_EN adds the packet_count[15:0] output.
// Revision : 1.0 - initial release
// ============================================================================
module niosii_system_st_packetizer #(
  parameter int PKT_LEN   = 320,
  parameter int CNT_WIDTH = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [9:0] out_data
`ifdef NIOSII_PACKETIZER_STATS_EN
  ,
  output logic [15:0] packet_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  logic                 in_ready_q,   in_ready_d;
  logic                 out_valid_q,  out_valid_d;
  logic [9:0]           out_data_q,   out_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [9:0]           skid_data_q,  skid_data_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q,   beat_cnt_d;

  logic       w_accept;
  logic       w_consume;
  logic [9:0] w_word;

  assign w_accept  = in_ready_q && in_valid;
  assign w_consume = out_valid_q && out_ready;
  // The tag comes from the counter value before it advances for this byte.
  assign w_word    = {(beat_cnt_q == '0), (beat_cnt_q == LAST_BEAT), in_data};

  // Next-state for the two-deep buffer, the beat counter and in_ready.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    beat_cnt_d   = beat_cnt_q;

    // Drain first: the skid refills the output, or the output empties.
    if (w_consume) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    // A new byte takes the output slot only if nothing older is queued ahead.
    if (w_accept) begin
      if ((!out_valid_q || w_consume) && !skid_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = w_word;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = w_word;
      end
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end

    // Deasserting together with the skid filling keeps a free slot for
    // any byte that could be accepted while in_ready is high.
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset discards any buffered beats and restarts framing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      beat_cnt_q   <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef NIOSII_PACKETIZER_STATS_EN
  logic [15:0] packet_count_q, packet_count_d;

  // Count completed packets: each handshake of an eop beat.
  always_comb begin
    packet_count_d = packet_count_q;
    if (w_consume && out_data_q[8]) begin
      packet_count_d = packet_count_q + 16'd1;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      packet_count_q <= '0;
    end else begin
      packet_count_q <= packet_count_d;
    end
  end

  assign packet_count = packet_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_niosii_system_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_niosii_system_st_packetizer
// Purpose  : Directed self-checking bench for niosii_system_st_packetizer.
//            dut4 uses PKT_LEN=4, dut1 uses PKT_LEN=1. The packet counter
//            section is built only with NIOSII_PACKETIZER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niosii_system_st_packetizer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_data;

  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1 = '0;
  logic       out_ready1 = 1'b0;
  logic       in_ready1;
  logic       out_valid1;
  logic [9:0] out_data1;

`ifdef NIOSII_PACKETIZER_STATS_EN
  logic [15:0] packet_count;
  logic [15:0] packet_count1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  niosii_system_st_packetizer #(.PKT_LEN(4), .CNT_WIDTH(12)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef NIOSII_PACKETIZER_STATS_EN
    ,
    .packet_count (packet_count)
`endif
  );

  niosii_system_st_packetizer #(.PKT_LEN(1), .CNT_WIDTH(12)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_ready  (in_ready1),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .out_ready (out_ready1),
    .out_valid (out_valid1),
    .out_data  (out_data1)
`ifdef NIOSII_PACKETIZER_STATS_EN
    ,
    .packet_count (packet_count1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] frame_exp [8];
  logic [9:0] stall_exp [8];

  initial begin
    int         idx;
    int         k;
    logic       acc;
    logic       cons;
    logic       stalled;
    logic [9:0] prev;

    frame_exp = '{10'h210, 10'h011, 10'h012, 10'h113,
                  10'h214, 10'h015, 10'h016, 10'h117};
    stall_exp = '{10'h230, 10'h031, 10'h032, 10'h133,
                  10'h234, 10'h035, 10'h036, 10'h137};

    // ---------------- reset values ----------------
    step();
    chk("rst_in_ready",  16'(in_ready),  16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data",  16'(out_data),  16'h0);
    reset_n = 1'b1;
    step();
    chk("in_ready_rise", 16'(in_ready), 16'h1);

    // ---------------- basic framing ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      step();
      chk("frame_valid", 16'(out_valid), 16'h1);
      chk($sformatf("frame_data%0d", i), 16'(out_data), 16'(frame_exp[i]));
    end
    in_valid = 1'b0;
    step();
    chk("frame_idle", 16'(out_valid), 16'h0);

    // ---------------- backpressure ----------------
    in_valid = 1'b1;
    in_data  = 8'h20;
    step();
    chk("bp_first", 16'(out_data), 16'h220);
    out_ready = 1'b0;
    in_data   = 8'h21;
    step();
    chk("bp_skid_full_rdy", 16'(in_ready), 16'h0);
    chk("bp_hold0", 16'(out_data), 16'h220);
    in_data = 8'h22;
    step();
    chk("bp_still_rdy0", 16'(in_ready), 16'h0);
    chk("bp_hold1", 16'(out_data), 16'h220);
    out_ready = 1'b1;
    step();
    chk("bp_drain_data", 16'(out_data), 16'h021);
    chk("bp_rdy_back", 16'(in_ready), 16'h1);
    step();
    chk("bp_next", 16'(out_data), 16'h022);
    in_data = 8'h23;
    step();
    chk("bp_eop", 16'(out_data), 16'h123);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 16'(out_valid), 16'h0);

    // ---------------- stalled output stability ----------------
    idx = 0;
    k   = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      out_ready = c[0];
      in_valid  = (idx < 8);
      in_data   = 8'h30 + 8'(idx);
      prev    = out_data;
      stalled = out_valid && !out_ready;
      cons    = out_valid && out_ready;
      acc     = in_ready && in_valid;
      if (cons) begin
        chk($sformatf("stall_seq%0d", k), 16'(out_data), 16'(stall_exp[k]));
        k++;
      end
      step();
      if (acc) idx++;
      if (stalled) chk("stall_hold", 16'(out_data), 16'(prev));
    end
    chk("stall_count", 16'(k), 16'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_empty", 16'(out_valid), 16'h0);

    // ---------------- single-beat packets ----------------
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_data1   = 8'hA0;
    step();
    chk("single0", 16'(out_data1), 16'h3A0);
    in_data1 = 8'hA1;
    step();
    chk("single1", 16'(out_data1), 16'h3A1);
    in_valid1 = 1'b0;
    step();

    // ---------------- reset mid-packet ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h40;
    step();
    in_data = 8'h41;
    step();
    in_valid = 1'b0;
    chk("mid_pre_valid", 16'(out_valid), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_data",  16'(out_data),  16'h0);
    chk("mid_rst_rdy",   16'(in_ready),  16'h0);
    step();
    chk("mid_rst_hold_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_hold_rdy",   16'(in_ready),  16'h0);
    reset_n = 1'b1;
    step();
    chk("mid_rdy_back", 16'(in_ready), 16'h1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    chk("mid_sop", 16'(out_data), 16'h255);
    in_valid = 1'b0;
    step();

`ifdef NIOSII_PACKETIZER_STATS_EN
    // ---------------- packet counter ----------------
    #2 reset_n = 1'b0;
    step();
    chk("stat_rst", packet_count, 16'h0);
    reset_n = 1'b1;
    step();
    idx = 0;
    k   = 0;
    for (int c = 0; c < 400 && k < 12; c++) begin
      out_ready = 1'($urandom_range(1));
      in_valid  = (idx < 12) && 1'($urandom_range(1));
      in_data   = 8'(idx);
      cons = out_valid && out_ready;
      acc  = in_ready && in_valid;
      step();
      if (acc) idx++;
      if (cons) k++;
    end
    chk("stat_beats", 16'(k), 16'd12);
    chk("stat_count3", packet_count, 16'd3);
    force dut4.packet_count_q = 16'hFFFF;
    #1 release dut4.packet_count_q;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h60 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stat_wrap", packet_count, 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
